scan_status_display: RTL and testbench

Parametrised, registered seven-segment status display for the scanner. It drives `NUM_DIGITS` active-low digits from the scanner's one-hot status code. Messages that fit are shown statically; longer messages scroll right-to-left at a programmable tick rate. It replaces the combinational status decoder and adds scrolling, freeze, a pass-complete pulse, and an optional blinking error indication.

---
 rtl/scan_status_display.sv | 206 ++++++++++++++++++++
 tb/tb_scan_status_display.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/scan_status_display.sv
// Seven-segment status display: decodes the scanner's one-hot status into text, scrolls long messages.
// Latency: status -> cur_status at edge N, hex shows the new message after edge N+1; scroll steps appear one edge after a tick.
// Backpressure: none; the display is free-running, and freeze only holds the scroll offset.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   status    one-hot scanner status code (5b)
//   freeze    holds the scroll offset while high (tick counter keeps running)
//   hex       active-low segments {g,f,e,d,c,b,a} per digit, digit 0 = hex[6:0] = rightmost
//   msg_done  one-cycle pulse when a scrolling message wraps back to offset 0
//
// Optional feature: define DISPLAY_BLINK_EN to show a blinking "Err" on invalid status codes.
module scan_status_display #(
  parameter int NUM_DIGITS  = 5,
  parameter int TICK_DIV    = 25_000_000,
  parameter int BLINK_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4:0]              status,
  input  logic                    freeze,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    msg_done
);

  if (NUM_DIGITS < 4 || NUM_DIGITS > 8 || TICK_DIV < 2 || BLINK_TICKS < 1) begin : g_param_check
    $error("scan_status_display: illegal parameter value");
  end

  localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]      NDIG      = 4'(NUM_DIGITS);

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_A     = 7'b0001000;
  localparam logic [6:0] G_C     = 7'b0100111;
  localparam logic [6:0] G_D     = 7'b0100001;
  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_F     = 7'b0001110;
  localparam logic [6:0] G_H     = 7'b0001011;
  localparam logic [6:0] G_I     = 7'b1111001;
  localparam logic [6:0] G_L     = 7'b1000111;
  localparam logic [6:0] G_N     = 7'b0101011;
  localparam logic [6:0] G_O     = 7'b0100011;
  localparam logic [6:0] G_R     = 7'b0101111;
  localparam logic [6:0] G_S     = 7'b0010010;
  localparam logic [6:0] G_T     = 7'b0000111;
  localparam logic [6:0] G_U     = 7'b1000001;

  // Message length; 0 marks an invalid status code.
  function automatic logic [3:0] msg_len(input logic [4:0] s);
    case (s)
      5'b01000: msg_len = 4'd4;  // IdLE
      5'b10000: msg_len = 4'd4;  // ScAn
      5'b00100: msg_len = 4'd8;  // trAnSFEr
      5'b00001: msg_len = 4'd5;  // FLUSh
      5'b00010: msg_len = 4'd4;  // donE
      default:  msg_len = 4'd0;
    endcase
  endfunction

  function automatic logic [6:0] msg_char(input logic [4:0] s, input logic [3:0] i);
    msg_char = G_BLANK;
    case (s)
      5'b01000:
        case (i)
          4'd0: msg_char = G_I;  4'd1: msg_char = G_D;
          4'd2: msg_char = G_L;  4'd3: msg_char = G_E;
          default: msg_char = G_BLANK;
        endcase
      5'b10000:
        case (i)
          4'd0: msg_char = G_S;  4'd1: msg_char = G_C;
          4'd2: msg_char = G_A;  4'd3: msg_char = G_N;
          default: msg_char = G_BLANK;
        endcase
      5'b00100:
        case (i)
          4'd0: msg_char = G_T;  4'd1: msg_char = G_R;
          4'd2: msg_char = G_A;  4'd3: msg_char = G_N;
          4'd4: msg_char = G_S;  4'd5: msg_char = G_F;
          4'd6: msg_char = G_E;  4'd7: msg_char = G_R;
          default: msg_char = G_BLANK;
        endcase
      5'b00001:
        case (i)
          4'd0: msg_char = G_F;  4'd1: msg_char = G_L;
          4'd2: msg_char = G_U;  4'd3: msg_char = G_S;
          4'd4: msg_char = G_H;
          default: msg_char = G_BLANK;
        endcase
      5'b00010:
        case (i)
          4'd0: msg_char = G_D;  4'd1: msg_char = G_O;
          4'd2: msg_char = G_N;  4'd3: msg_char = G_E;
          default: msg_char = G_BLANK;
        endcase
      default: msg_char = G_BLANK;
    endcase
  endfunction

  logic [4:0]              cur_status;
  logic [3:0]              offset;
  logic [TW-1:0]           tick_cnt;
  logic [7*NUM_DIGITS-1:0] hex_nxt;

  logic [3:0] len;
  logic       valid;
  logic       scroll;
  logic       tick;
  logic       chg;

  assign len    = msg_len(cur_status);
  assign valid  = (len != 4'd0);
  assign scroll = (len > NDIG);
  assign tick   = (tick_cnt == TICK_LAST);
  assign chg    = (status != cur_status);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_status <= 5'b00000;
      offset     <= 4'd0;
      tick_cnt   <= '0;
      hex        <= '1;
      msg_done   <= 1'b0;
    end else begin
      hex      <= hex_nxt;
      msg_done <= 1'b0;
      if (chg) begin
        // A status change restarts the message and beats any coincident tick.
        cur_status <= status;
        offset     <= 4'd0;
        tick_cnt   <= '0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        if (tick && scroll && !freeze) begin
          if (offset == len) begin
            offset   <= 4'd0;
            msg_done <= 1'b1;
          end else begin
            offset <= offset + 4'd1;
          end
        end
      end
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int            BW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Runs on every tick regardless of freeze; restarted on each status change
  // so an invalid code always opens with the visible "Err" half-period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (chg) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`endif

  // Per-digit glyph selection. POS is the window position counted from the left.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    localparam logic [4:0] POS = 5'(NUM_DIGITS - 1 - d);
    logic [4:0] len_p1;
    logic [4:0] sum;
    logic [6:0] seg;

    always_comb begin
      len_p1 = {1'b0, len} + 5'd1;
      sum    = {1'b0, offset} + POS;
      // offset <= L and POS < L when scrolling, so one subtraction covers the mod.
      if (scroll && sum >= len_p1) sum = sum - len_p1;
      // Ring slot L (the separator) and anything past a static message are blank.
      if (sum >= {1'b0, len}) seg = G_BLANK;
      else                    seg = msg_char(cur_status, sum[3:0]);
`ifdef DISPLAY_BLINK_EN
      if (!valid) begin
        if (blink_phase || POS > 5'd2) seg = G_BLANK;
        else if (POS == 5'd0)          seg = G_E;
        else                           seg = G_R;
      end
`else
      if (!valid) seg = G_BLANK;
`endif
    end

    assign hex_nxt[7*d +: 7] = seg;
  end

endmodule

// File: tb/tb_scan_status_display.sv
// Directed bench for scan_status_display with NUM_DIGITS=5, TICK_DIV=4, BLINK_TICKS=2.
// Inputs change and outputs are sampled 1 time unit after the falling edge.
module tb_scan_status_display;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  status;
  logic        freeze;
  logic [34:0] hex;
  logic        msg_done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int base;

  localparam logic [34:0] BLANK = {35{1'b1}};

  scan_status_display #(
    .NUM_DIGITS (5),
    .TICK_DIV   (4),
    .BLINK_TICKS(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .status  (status),
    .freeze  (freeze),
    .hex     (hex),
    .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (msg_done === 1'b1) done_cnt++;

  // Expected windows of "trAnSFEr" + blank, one per offset (hand-derived).
  string win_tbl[9] = '{"trAnS", "rAnSF", "AnSFE", "nSFEr", "SFEr ",
                        "FEr t", "Er tr", "r trA", " trAn"};

  function automatic logic [6:0] glyph(input byte c);
    case (c)
      "A": glyph = 7'b0001000;  "c": glyph = 7'b0100111;
      "d": glyph = 7'b0100001;  "E": glyph = 7'b0000110;
      "F": glyph = 7'b0001110;  "h": glyph = 7'b0001011;
      "I": glyph = 7'b1111001;  "L": glyph = 7'b1000111;
      "n": glyph = 7'b0101011;  "o": glyph = 7'b0100011;
      "r": glyph = 7'b0101111;  "S": glyph = 7'b0010010;
      "t": glyph = 7'b0000111;  "U": glyph = 7'b1000001;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // First character is the leftmost digit (digit 4).
  function automatic logic [34:0] win(input string s);
    logic [34:0] w;
    w = BLANK;
    for (int i = 0; i < 5; i++) w[7*(4-i) +: 7] = glyph(s[i]);
    return w;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    status  = 5'b01000;
    freeze  = 1'b0;

    // Reset state
    cyc(2);
    chk("reset_hex", hex, BLANK);
    chk("reset_done", {34'd0, msg_done}, 35'd0);

    // Release: cur_status loads at the first edge, IdLE appears after the second
    reset_n = 1'b1;
    cyc(2);
    chk("idle_msg", hex, win("IdLE "));
    base = done_cnt;
    cyc(40);
    chk("idle_static", hex, win("IdLE "));
    chk("idle_no_done", 35'(done_cnt - base), 35'd0);

    // Scroll trAnSFEr: status loads at edge A, offset j visible after edge A+1+4j
    status = 5'b00100;
    base   = done_cnt;
    cyc(2);
    chk("scroll_w0", hex, win(win_tbl[0]));
    for (int j = 1; j < 9; j++) begin
      cyc(4);
      chk($sformatf("scroll_w%0d", j), hex, win(win_tbl[j]));
    end
    // now after A+33; the wrapping tick is edge A+36
    cyc(2);
    chk("pre_wrap_done", {34'd0, msg_done}, 35'd0);
    cyc(1);
    chk("wrap_done", {34'd0, msg_done}, 35'd1);
    cyc(1);
    chk("wrap_done_1cyc", {34'd0, msg_done}, 35'd0);
    chk("wrap_w0", hex, win(win_tbl[0]));
    cyc(35);  // after A+72: second pass completes
    chk("pass2_done", {34'd0, msg_done}, 35'd1);
    chk("pass_count", 35'(done_cnt - base), 35'd2);

    // Freeze at offset 8 across the wrapping tick
    cyc(34);  // after A+106, offset 8 shown
    chk("pre_freeze_w8", hex, win(win_tbl[8]));
    freeze = 1'b1;
    base   = done_cnt;
    cyc(20);  // after A+126, five ticks blocked
    chk("freeze_hold", hex, win(win_tbl[8]));
    chk("freeze_no_done", 35'(done_cnt - base), 35'd0);
    freeze = 1'b0;
    cyc(2);   // after A+128: wrapping tick
    chk("unfreeze_done", {34'd0, msg_done}, 35'd1);
    chk("unfreeze_still_w8", hex, win(win_tbl[8]));
    cyc(1);
    chk("unfreeze_w0", hex, win(win_tbl[0]));

    // Status change coinciding with the wrapping tick at A+164
    cyc(34);  // after A+163
    chk("pre_restart_w8", hex, win(win_tbl[8]));
    status = 5'b00001;
    base   = done_cnt;
    cyc(1);
    chk("restart_no_done", {34'd0, msg_done}, 35'd0);
    cyc(1);
    chk("flush_msg", hex, win("FLUSh"));
    cyc(40);
    chk("flush_static", hex, win("FLUSh"));
    chk("flush_no_done", 35'(done_cnt - base), 35'd0);

    status = 5'b00010;
    cyc(2);
    chk("done_msg", hex, win("donE "));

    // Invalid code: entry edge C, hex after C+1
    status = 5'b00011;
    cyc(2);
`ifdef DISPLAY_BLINK_EN
    chk("err_on_first", hex, win("Err  "));
    cyc(7);
    chk("err_on_last", hex, win("Err  "));
    cyc(1);
    chk("err_off_first", hex, BLANK);
    cyc(7);
    chk("err_off_last", hex, BLANK);
    cyc(1);
    chk("err_on_again", hex, win("Err  "));
`else
    chk("inv_blank0", hex, BLANK);
    cyc(7);
    chk("inv_blank7", hex, BLANK);
    cyc(1);
    chk("inv_blank8", hex, BLANK);
    cyc(8);
    chk("inv_blank16", hex, BLANK);
`endif

    // Async reset mid-scroll, asserted between clock edges
    status = 5'b00100;
    cyc(14);  // status loaded at edge D; after D+13 shows offset 3
    chk("pre_rst_w3", hex, win(win_tbl[3]));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_hex", hex, BLANK);
    chk("async_rst_done", {34'd0, msg_done}, 35'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    chk("post_rst_w0", hex, win(win_tbl[0]));
    cyc(4);
    chk("post_rst_w1", hex, win(win_tbl[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
